ofdm_cp_insert: RTL

Parametrised cyclic-prefix inserter for the OFDM transmit chain, placed between the IFFT stage and the output stage on the Wishbone-style streaming bus. It buffers one full time-domain symbol of `N = 2**LOG2N` samples in a ping-pong memory. It then emits the last `CP` samples followed by all `N` samples. The CP length is selectable per symbol from the four 802.22 ratios (1/4, 1/8, 1/16, 1/32). Ping-pong banking lets the next symbol be written while the previous one is read.

---
 rtl/ofdm_pkg.sv | 25 ++
 rtl/ofdm_sym_ram.sv | 30 +++
 rtl/ofdm_cp_insert.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM transmit chain: CP mode encoding,
// CP length arithmetic and the cyclic-prefix read FSM state type.
package ofdm_pkg;

    typedef enum logic [1:0] {
        CP_1_4  = 2'b00,
        CP_1_8  = 2'b01,
        CP_1_16 = 2'b10,
        CP_1_32 = 2'b11
    } cp_mode_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_t;

    localparam int unsigned LOG2N_MIN = 5;

    // CP length in samples: N/4, N/8, N/16 or N/32.
    function automatic int unsigned cp_len(input cp_mode_t mode, input int unsigned log2n);
        return (32'd1 << log2n) >> (32'd2 + 32'(mode));
    endfunction

endpackage

// File: rtl/ofdm_sym_ram.sv
// Simple dual-port symbol RAM: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module ofdm_sym_ram #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: buffers one N-sample symbol per ping-pong bank and
// replays the last CP samples followed by the whole symbol.
module ofdm_cp_insert
    import ofdm_pkg::*;
#(
    parameter int DW    = 32,
    parameter int LOG2N = 11
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    output logic          ACK_O,
    input  logic [1:0]    CP_MODE_I,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] cp_start(input cp_mode_t m);
        return LOG2N'(N - cp_len(m, LOG2N));
    endfunction

    // ---------------- write side ----------------
    logic             wr_bank_reg;
    logic [LOG2N-1:0] wr_cnt_reg;
    logic [1:0]       full_reg;
    cp_mode_t         cp_mode_reg [2];
    logic             wr_ack;
    logic             wr_fill;

    assign wr_ack  = CYC_I & STB_I & WE_I & ~full_reg[wr_bank_reg];
    assign wr_fill = wr_ack && (wr_cnt_reg == LAST);
    assign ACK_O   = wr_ack;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
        end else if (wr_ack) begin
            if (wr_fill) begin
                wr_cnt_reg  <= '0;
                wr_bank_reg <= ~wr_bank_reg;
            end else begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end else if (!CYC_I && (wr_cnt_reg != '0)) begin
            // Bus cycle abandoned mid-symbol: drop the partial symbol.
            wr_cnt_reg <= '0;
        end
    end

    // ---------------- read FSM ----------------
    rd_state_t        state_reg;
    logic             rd_bank_reg;
    logic [LOG2N-1:0] rd_addr_reg;
    logic             rd_vld_reg;
    logic             rd_issue;
    logic             rd_free;
    logic             issue_ok;
    logic [LOG2N-1:0] issue_addr;
    logic [LOG2N-1:0] cur_start;
    logic [LOG2N-1:0] nxt_start;
    logic             other_full;
    logic [DW-1:0]    ram_rd_data;

    // ---------------- output stage registers ----------------
    logic [DW-1:0] dat_reg;
    logic          stb_reg;
    logic [DW-1:0] skid_dat_reg;
    logic          skid_vld_reg;
    logic          cyc_reg;
    logic          pop;
    logic [1:0]    occ;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic set_full;
            logic clr_full;

            assign set_full = wr_fill && (wr_bank_reg == 1'(gi));
            assign clr_full = rd_free && (rd_bank_reg == 1'(gi));

            always_ff @(posedge CLK_I or negedge RST_I) begin
                if (!RST_I) begin
                    full_reg[gi] <= 1'b0;
                end else if (set_full) begin
                    full_reg[gi] <= 1'b1;
                end else if (clr_full) begin
                    full_reg[gi] <= 1'b0;
                end
            end

            always_ff @(posedge CLK_I or negedge RST_I) begin
                if (!RST_I) begin
                    cp_mode_reg[gi] <= CP_1_4;
                end else if (wr_ack && (wr_bank_reg == 1'(gi)) && (wr_cnt_reg == '0)) begin
                    cp_mode_reg[gi] <= cp_mode_t'(CP_MODE_I);
                end
            end
        end
    endgenerate

    // Reads are issued only when the output register plus skid can absorb the
    // result one cycle later, so nothing in flight is ever dropped.
    always_comb begin
        pop        = stb_reg & ACK_I;
        occ        = 2'(stb_reg) + 2'(skid_vld_reg) + 2'(rd_vld_reg);
        issue_ok   = (occ - 2'(pop)) < 2'd2;
        cur_start  = cp_start(cp_mode_reg[rd_bank_reg]);
        nxt_start  = cp_start(cp_mode_reg[~rd_bank_reg]);
        other_full = full_reg[~rd_bank_reg];
        rd_issue   = issue_ok && ((state_reg != RD_IDLE) || full_reg[rd_bank_reg]);
        issue_addr = (state_reg == RD_IDLE) ? cur_start : rd_addr_reg;
        rd_free    = rd_issue && (state_reg == RD_BODY) && (rd_addr_reg == LAST);
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg   <= RD_IDLE;
            rd_bank_reg <= 1'b0;
            rd_addr_reg <= '0;
        end else if (rd_issue) begin
            case (state_reg)
                RD_IDLE: begin
                    // The CP start address is issued in the same cycle the symbol is seen.
                    rd_addr_reg <= issue_addr + 1'b1;
                    state_reg   <= (issue_addr == LAST) ? RD_BODY : RD_CP;
                end
                RD_CP: begin
                    rd_addr_reg <= rd_addr_reg + 1'b1;
                    if (rd_addr_reg == LAST) begin
                        state_reg <= RD_BODY;
                    end
                end
                RD_BODY: begin
                    if (rd_addr_reg == LAST) begin
                        rd_bank_reg <= ~rd_bank_reg;
                        if (other_full) begin
                            state_reg   <= RD_CP;
                            rd_addr_reg <= nxt_start;
                        end else begin
                            state_reg   <= RD_IDLE;
                            rd_addr_reg <= '0;
                        end
                    end else begin
                        rd_addr_reg <= rd_addr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= RD_IDLE;
                end
            endcase
        end
    end

    ofdm_sym_ram #(
        .DW(DW),
        .AW(LOG2N + 1)
    ) u_ram (
        .clk    (CLK_I),
        .wr_en  (wr_ack),
        .wr_addr({wr_bank_reg, wr_cnt_reg}),
        .wr_data(DAT_I),
        .rd_en  (rd_issue),
        .rd_addr({rd_bank_reg, issue_addr}),
        .rd_data(ram_rd_data)
    );

    // ---------------- output register with one-entry skid ----------------
    logic          stb_next;
    logic [DW-1:0] dat_next;
    logic          skid_vld_next;
    logic [DW-1:0] skid_dat_next;
    logic          cyc_next;

    always_comb begin
        stb_next      = stb_reg;
        dat_next      = dat_reg;
        skid_vld_next = skid_vld_reg;
        skid_dat_next = skid_dat_reg;
        if (!stb_reg || pop) begin
            if (skid_vld_reg) begin
                stb_next      = 1'b1;
                dat_next      = skid_dat_reg;
                skid_vld_next = rd_vld_reg;
                skid_dat_next = ram_rd_data;
            end else if (rd_vld_reg) begin
                stb_next = 1'b1;
                dat_next = ram_rd_data;
            end else begin
                stb_next = 1'b0;
            end
        end else if (rd_vld_reg) begin
            skid_vld_next = 1'b1;
            skid_dat_next = ram_rd_data;
        end
        // CYC_O rises with a strobe and only falls once nothing remains to send.
        cyc_next = stb_next | (cyc_reg & (skid_vld_next | rd_issue | rd_vld_reg |
                                          (state_reg != RD_IDLE) | (|full_reg)));
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            rd_vld_reg   <= 1'b0;
            stb_reg      <= 1'b0;
            dat_reg      <= '0;
            skid_vld_reg <= 1'b0;
            skid_dat_reg <= '0;
            cyc_reg      <= 1'b0;
        end else begin
            rd_vld_reg   <= rd_issue;
            stb_reg      <= stb_next;
            dat_reg      <= dat_next;
            skid_vld_reg <= skid_vld_next;
            skid_dat_reg <= skid_dat_next;
            cyc_reg      <= cyc_next;
        end
    end

    assign DAT_O = dat_reg;
    assign STB_O = stb_reg;
    assign WE_O  = stb_reg;
    assign CYC_O = cyc_reg;

endmodule
